// File: rtl/node_turn_ctrl.sv
// Node-turn controller: settle, count node/lap, execute commanded turn, re-acquire line, hand back.
// Registered outputs follow the next state, so they change on the same edge as the state.
module node_turn_ctrl #(
   parameter int N_CH          = 3,
   parameter int ADC_W         = 12,
   parameter int LINE_TH       = 1280,
   parameter int DUTY_W        = 8,
   parameter int FWD_L         = 77,
   parameter int FWD_R         = 80,
   parameter int TURN_L        = 77,
   parameter int TURN_R        = 80,
   parameter int SETTLE_CYC    = 21000000,
   parameter int MIN_TURN_CYC  = 25000000,
   parameter int UTURN_CYC     = 50000000,
   parameter int TIMEOUT_CYC   = 150000000,
   parameter int NODES_PER_LAP = 8,
   parameter int CNT_W         = 32
) (
   input  logic                    clk_50,
   input  logic                    rst_n,
   input  logic                    node,
   input  logic [N_CH*ADC_W-1:0]   ch_flat,
   input  logic [1:0]              direction,
   output logic [DUTY_W-1:0]       lm,
   output logic [DUTY_W-1:0]       lmn,
   output logic [DUTY_W-1:0]       rm,
   output logic [DUTY_W-1:0]       rmn,
   output logic                    node_done,
   output logic                    fault,
   output logic [4:0]              node_count,
   output logic [2:0]              lap,
   output logic                    busy
);

   localparam logic [CNT_W-1:0]  ONE          = CNT_W'(1);
   localparam logic [CNT_W-1:0]  SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0]  MIN_TURN_V   = CNT_W'(MIN_TURN_CYC);
   localparam logic [CNT_W-1:0]  UTURN_V      = CNT_W'(UTURN_CYC);
   localparam logic [CNT_W-1:0]  TIMEOUT_V    = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [ADC_W-1:0]  LINE_V       = ADC_W'(LINE_TH);
   localparam logic [DUTY_W-1:0] FWD_L_V      = DUTY_W'(FWD_L);
   localparam logic [DUTY_W-1:0] FWD_R_V      = DUTY_W'(FWD_R);
   localparam logic [DUTY_W-1:0] TURN_L_V     = DUTY_W'(TURN_L);
   localparam logic [DUTY_W-1:0] TURN_R_V     = DUTY_W'(TURN_R);
   localparam logic [4:0]        NPL_V        = 5'(NODES_PER_LAP);

   typedef enum logic [2:0] {IDLE, SETTLE, COUNT, TURN, DONE, FAULT} state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  timer, timer_nx, timer_inc, blind;
   logic [1:0]        dir_q, dir_eff;
   logic              line_det;
   logic              count_hit;
   logic [DUTY_W-1:0] lm_nx, lmn_nx, rm_nx, rmn_nx;
   logic              done_nx, fault_nx;

   always_comb begin
      line_det = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         if (ch_flat[k*ADC_W +: ADC_W] > LINE_V) line_det = 1'b1;
      end
   end

   assign timer_inc = (timer >= TIMEOUT_V) ? timer : timer + ONE;
   assign blind     = (dir_q == 2'd0) ? UTURN_V : MIN_TURN_V;
   // During COUNT the latch has not happened yet, so the first TURN pattern uses the live input
   assign dir_eff   = (state == COUNT) ? direction : dir_q;

   always_comb begin
      state_nx = state;
      timer_nx = timer;
      case (state)
         IDLE: begin
            timer_nx = '0;
            if (node) state_nx = SETTLE;
         end
         SETTLE: begin
            timer_nx = timer_inc;
            if (timer == SETTLE_LAST) state_nx = COUNT;
         end
         COUNT: begin
            timer_nx = '0;
            state_nx = (direction == 2'd3) ? DONE : TURN;
         end
         TURN: begin
            timer_nx = timer_inc;
            if (line_det && (timer >= blind)) state_nx = DONE;
            else if (timer == TIMEOUT_LAST)   state_nx = FAULT;
         end
         DONE, FAULT: begin
            state_nx = state;
         end
         default: state_nx = IDLE;
      endcase
      if ((state != IDLE) && !node) begin
         state_nx = IDLE;
         timer_nx = '0;
      end
   end

   assign count_hit = (state == SETTLE) && (state_nx == COUNT);

   always_comb begin
      lm_nx    = FWD_L_V;
      rm_nx    = FWD_R_V;
      lmn_nx   = '0;
      rmn_nx   = '0;
      done_nx  = 1'b0;
      fault_nx = 1'b0;
      case (state_nx)
         COUNT, DONE, FAULT: begin
            lm_nx    = '0;
            rm_nx    = '0;
            done_nx  = (state_nx == DONE);
            fault_nx = (state_nx == FAULT);
         end
         TURN: begin
            if (dir_eff == 2'd2) begin
               lm_nx  = TURN_L_V;
               rm_nx  = '0;
               rmn_nx = TURN_R_V;
            end else begin
               lm_nx  = '0;
               lmn_nx = TURN_L_V;
               rm_nx  = TURN_R_V;
            end
         end
         default: begin
            lm_nx = FWD_L_V;
         end
      endcase
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         timer      <= '0;
         dir_q      <= 2'd3;
         lm         <= FWD_L_V;
         rm         <= FWD_R_V;
         lmn        <= '0;
         rmn        <= '0;
         node_done  <= 1'b0;
         fault      <= 1'b0;
         node_count <= 5'd0;
         lap        <= 3'd1;
         busy       <= 1'b0;
      end else begin
         state     <= state_nx;
         timer     <= timer_nx;
         lm        <= lm_nx;
         rm        <= rm_nx;
         lmn       <= lmn_nx;
         rmn       <= rmn_nx;
         node_done <= done_nx;
         fault     <= fault_nx;
         busy      <= (state_nx != IDLE);
         if (state == COUNT) dir_q <= direction;
         if (count_hit) begin
            if (node_count == NPL_V) begin
               node_count <= 5'd1;
               if (lap != 3'd7) lap <= lap + 3'd1;
            end else begin
               node_count <= node_count + 5'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_node_turn_ctrl.sv
// Directed bench for node_turn_ctrl with short sim timings (settle 10, blind 20/40, timeout 100).
module tb_node_turn_ctrl;
   localparam int ADC_W = 12;
   localparam int N_CH  = 3;

   logic                  clk_50 = 1'b0;
   logic                  rst_n;
   logic                  node;
   logic [N_CH*ADC_W-1:0] ch_flat;
   logic [1:0]            direction;
   logic [7:0]            lm, lmn, rm, rmn;
   logic                  node_done, fault, busy;
   logic [4:0]            node_count;
   logic [2:0]            lap;

   int n_cmp = 0;
   int n_bad = 0;

   node_turn_ctrl #(
      .N_CH(N_CH), .ADC_W(ADC_W),
      .SETTLE_CYC(10), .MIN_TURN_CYC(20), .UTURN_CYC(40), .TIMEOUT_CYC(100)
   ) dut (
      .clk_50(clk_50), .rst_n(rst_n), .node(node), .ch_flat(ch_flat), .direction(direction),
      .lm(lm), .lmn(lmn), .rm(rm), .rmn(rmn), .node_done(node_done), .fault(fault),
      .node_count(node_count), .lap(lap), .busy(busy)
   );

   always #5 clk_50 = ~clk_50;

   task automatic step();
      @(posedge clk_50);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Raises node and runs to the COUNT cycle (10 settle cycles after the rise edge)
   task automatic start_node(input logic [1:0] d, input int exp_cnt, input int exp_lap);
      direction = d;
      node      = 1'b1;
      repeat (11) step();
      chk("count_node_count", 32'(node_count), 32'(exp_cnt));
      chk("count_lap", 32'(lap), 32'(exp_lap));
   endtask

   initial begin
      rst_n = 1'b0; node = 1'b0; ch_flat = '0; direction = 2'd3;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      chk("rst_lm", 32'(lm), 32'd77);
      chk("rst_rm", 32'(rm), 32'd80);
      chk("rst_lmn", 32'(lmn), 32'd0);
      chk("rst_rmn", 32'(rmn), 32'd0);
      chk("rst_done", 32'(node_done), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_count", 32'(node_count), 32'd0);
      chk("rst_lap", 32'(lap), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);

      // Straight: still settling on the 10th edge, COUNT on the 11th
      direction = 2'd3; node = 1'b1;
      repeat (10) step();
      chk("str_settle_lm", 32'(lm), 32'd77);
      chk("str_settle_cnt", 32'(node_count), 32'd0);
      chk("str_settle_busy", 32'(busy), 32'd1);
      step();
      chk("str_count_cnt", 32'(node_count), 32'd1);
      chk("str_count_lm", 32'(lm), 32'd0);
      chk("str_count_rm", 32'(rm), 32'd0);
      chk("str_count_done", 32'(node_done), 32'd0);
      step();
      chk("str_done", 32'(node_done), 32'd1);
      chk("str_done_lm", 32'(lm), 32'd0);
      chk("str_done_rm", 32'(rm), 32'd0);
      repeat (18) step();
      chk("str_done_held", 32'(node_done), 32'd1);
      node = 1'b0;
      step();
      chk("str_back_lm", 32'(lm), 32'd77);
      chk("str_back_rm", 32'(rm), 32'd80);
      chk("str_back_done", 32'(node_done), 32'd0);
      chk("str_back_busy", 32'(busy), 32'd0);

      // Left turn, line on ch1 from turn cycle 5; exit decided at timer 20
      start_node(2'd1, 2, 1);
      step();
      chk("left_t0_lmn", 32'(lmn), 32'd77);
      chk("left_t0_rm", 32'(rm), 32'd80);
      chk("left_t0_lm", 32'(lm), 32'd0);
      chk("left_t0_rmn", 32'(rmn), 32'd0);
      repeat (5) step();
      ch_flat[ADC_W*1 +: ADC_W] = 12'd2000;
      repeat (14) step();
      chk("left_t19_done", 32'(node_done), 32'd0);
      step();
      chk("left_t20_lmn", 32'(lmn), 32'd77);
      step();
      chk("left_t21_done", 32'(node_done), 32'd1);
      chk("left_t21_lmn", 32'(lmn), 32'd0);
      node = 1'b0;
      ch_flat[ADC_W*1 +: ADC_W] = 12'd1280;
      step();

      // Left turn with ch1 at threshold: never detected, fault after 100 turn cycles
      start_node(2'd1, 3, 1);
      step();
      repeat (99) step();
      chk("tmo_t99_fault", 32'(fault), 32'd0);
      chk("tmo_t99_lmn", 32'(lmn), 32'd77);
      step();
      chk("tmo_t100_fault", 32'(fault), 32'd1);
      chk("tmo_t100_done", 32'(node_done), 32'd0);
      chk("tmo_t100_lmn", 32'(lmn), 32'd0);
      node = 1'b0;
      ch_flat = '0;
      step();
      chk("tmo_clear_fault", 32'(fault), 32'd0);
      chk("tmo_clear_busy", 32'(busy), 32'd0);

      // Right turn on ch2; a direction change mid-turn must not alter the pattern
      start_node(2'd2, 4, 1);
      ch_flat[ADC_W*2 +: ADC_W] = 12'd4095;
      step();
      chk("right_t0_lm", 32'(lm), 32'd77);
      chk("right_t0_rmn", 32'(rmn), 32'd80);
      chk("right_t0_lmn", 32'(lmn), 32'd0);
      chk("right_t0_rm", 32'(rm), 32'd0);
      repeat (3) step();
      direction = 2'd1;
      repeat (7) step();
      chk("right_t10_lm", 32'(lm), 32'd77);
      chk("right_t10_rmn", 32'(rmn), 32'd80);
      chk("right_t10_done", 32'(node_done), 32'd0);
      repeat (11) step();
      chk("right_t21_done", 32'(node_done), 32'd1);
      node = 1'b0;
      ch_flat = '0;
      step();

      // U-turn, line on ch0 from turn cycle 25; blind time 40
      start_node(2'd0, 5, 1);
      step();
      chk("u_t0_lmn", 32'(lmn), 32'd77);
      chk("u_t0_rm", 32'(rm), 32'd80);
      repeat (25) step();
      ch_flat[ADC_W*0 +: ADC_W] = 12'd3000;
      repeat (14) step();
      chk("u_t39_done", 32'(node_done), 32'd0);
      step();
      chk("u_t40_done", 32'(node_done), 32'd0);
      chk("u_t40_lmn", 32'(lmn), 32'd77);
      step();
      chk("u_t41_done", 32'(node_done), 32'd1);
      node = 1'b0;
      ch_flat = '0;
      step();

      // Abort at settle cycle 5
      direction = 2'd3; node = 1'b1;
      repeat (6) step();
      chk("abort_settle_busy", 32'(busy), 32'd1);
      node = 1'b0;
      step();
      chk("abort_idle_busy", 32'(busy), 32'd0);
      chk("abort_idle_lm", 32'(lm), 32'd77);
      chk("abort_idle_cnt", 32'(node_count), 32'd5);
      chk("abort_idle_done", 32'(node_done), 32'd0);
      repeat (15) step();
      chk("abort_later_done", 32'(node_done), 32'd0);
      chk("abort_later_cnt", 32'(node_count), 32'd5);

      // Asynchronous reset in the middle of a turn
      start_node(2'd1, 6, 1);
      repeat (8) step();
      chk("mid_turn_lmn", 32'(lmn), 32'd77);
      rst_n = 1'b0;
      #1;
      chk("arst_lm", 32'(lm), 32'd77);
      chk("arst_rm", 32'(rm), 32'd80);
      chk("arst_lmn", 32'(lmn), 32'd0);
      chk("arst_rmn", 32'(rmn), 32'd0);
      chk("arst_cnt", 32'(node_count), 32'd0);
      chk("arst_lap", 32'(lap), 32'd1);
      chk("arst_busy", 32'(busy), 32'd0);
      node = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      // Nine straight nodes: count 1..8 then wraps to 1 with lap 2
      for (int i = 1; i <= 9; i++) begin
         start_node(2'd3, (i <= 8) ? i : 1, (i <= 8) ? 1 : 2);
         step();
         chk("lap_done", 32'(node_done), 32'd1);
         node = 1'b0;
         step();
      end
      chk("lap_final", 32'(lap), 32'd2);
      chk("lap_final_cnt", 32'(node_count), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/node_turn_ctrl.md
Name: node_turn_ctrl

Overview:
- Parametrised successor of the bot's node-turn controller.
- On a node event it:
  - waits a settle delay,
  - updates node and lap counters,
  - executes the commanded turn (straight, left, right or U-turn) with minimum blind times and a timeout,
  - re-acquires the line on any of N ADC line channels,
  - hands control back to the line follower.
- Sits between the node detector / path planner and the motor PWM stage.

Parameters:
- N_CH, 3, number of line-sensor ADC channels
- ADC_W, 12, width of each ADC sample
- LINE_TH, 1280, line present when a sample is strictly greater than this value
- DUTY_W, 8, width of the motor duty words
- FWD_L, 77, left forward duty used while following
- FWD_R, 80, right forward duty used while following
- TURN_L, 77, left duty used while turning
- TURN_R, 80, right duty used while turning
- SETTLE_CYC, 21000000, cycles from node rise to count/turn
- MIN_TURN_CYC, 25000000, blind cycles before line re-acquire (left/right)
- UTURN_CYC, 50000000, blind cycles before line re-acquire (U-turn)
- TIMEOUT_CYC, 150000000, turn abort limit
- NODES_PER_LAP, 8, node count wrap point
- CNT_W, 32, timer width; must hold TIMEOUT_CYC

Ports:
- clk_50  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- node  in  1  node-present level from the node detector
- ch_flat  in  N_CH*ADC_W  packed ADC samples; channel k is bits [k*ADC_W +: ADC_W]
- direction  in  2  0=U-turn, 1=left, 2=right, 3=straight; sampled in COUNT
- lm, lmn, rm, rmn  out  DUTY_W each  left/right forward/reverse duty words
- node_done  out  1  turn complete; hand back to follower
- fault  out  1  turn timed out
- node_count  out  5  node index within lap, 0..NODES_PER_LAP
- lap  out  3  lap number, starts at 1, saturates at 7
- busy  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered. On rst_n low (asynchronous):
  - state=IDLE, timer=0
  - lm=FWD_L, rm=FWD_R, lmn=rmn=0
  - node_done=fault=0, node_count=0, lap=1
- line_det (combinational) = OR over channels of (sample > LINE_TH).
- IDLE:
  - Outputs: follow duties, node_done=fault=0, timer=0.
  - node=1 -> SETTLE.
- SETTLE:
  - Follow duties held; timer increments each cycle.
  - timer == SETTLE_CYC-1 -> COUNT.
- COUNT (exactly 1 cycle):
  - All duties 0.
  - Counter update: if node_count==NODES_PER_LAP then node_count=1 and lap=lap+1 (saturating at 7); else node_count+1.
  - Latch direction into dir_q; timer cleared.
  - Next state: dir=3 -> DONE; else -> TURN.
- TURN:
  - Duty patterns:
    - dir 1 and dir 0: lmn=TURN_L, rm=TURN_R, lm=rmn=0.
    - dir 2: lm=TURN_L, rmn=TURN_R, lmn=rm=0.
  - Timer increments each cycle.
  - Exit to DONE when line_det=1 and timer >= blind, where blind = UTURN_CYC for dir 0, otherwise MIN_TURN_CYC.
  - timer == TIMEOUT_CYC-1 without exit -> FAULT. Timeout is checked after exit, so a simultaneous line_det wins.
- DONE: all duties 0, node_done=1; remain until node=0.
- FAULT: all duties 0, fault=1, node_done=0; remain until node=0.
- node=0 in any non-IDLE state -> IDLE on the next edge.
  - Follow duties restored; node_done/fault cleared.
  - Counters keep their values, including an abort during SETTLE (no count).
- The timer never wraps; it saturates at TIMEOUT_CYC.
- A direction change after COUNT is ignored until the next node.
- node re-rising after IDLE is a new node event.

Test Plan:
- Sim parameters throughout: SETTLE_CYC=10, MIN_TURN_CYC=20, UTURN_CYC=40, TIMEOUT_CYC=100.
- Reset mid-TURN: assert rst_n=0 -> same cycle shows lm=77, rm=80, lmn=rmn=0, node_count=0, lap=1, busy=0.
- Straight:
  - Stimulus: direction=3, node high 30 cycles.
  - Required response: COUNT 10 cycles after the node rise edge; node_count 0->1; node_done=1 from the next cycle with all duties 0; after node=0, follow duties back the next cycle.
- Left turn:
  - Stimulus: direction=1, ch1=2000 present from turn cycle 5.
  - Required response: lmn=77, rm=80 for 20 turn cycles, then node_done=1.
  - Repeat with ch1=1280 (not > LINE_TH): must time out with fault=1 at turn cycle 100.
- U-turn:
  - Stimulus: direction=0, line present from turn cycle 25.
  - Required response: no exit before cycle 40, exit at cycle 40.
- Lap wrap:
  - Stimulus: 9 straight node events.
  - Required response: node_count 1..8 then 1; lap goes 1->2 on the 9th.
- Abort: node drops at settle cycle 5 -> IDLE next cycle; node_count unchanged; no node_done pulse.
